reg_dump_scanner: RTL and testbench

REG_DUMP_SCANNER -- requirements
Module: reg_dump_scanner

---
 rtl/reg_dump_scanner_if.sv | 23 ++
 rtl/reg_dump_scanner.sv | 151 +++++++++++++++
 tb/tb_reg_dump_scanner.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_scanner_if.sv
// Record stream from the register-dump scanner to its consumer.
// A record transfers on a clock edge where out_valid and out_ready are both high; while
// out_valid is high and out_ready is low the producer holds out_idx/out_data unchanged.
interface reg_dump_scanner_if;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/reg_dump_scanner.sv
// Walks the register file debug port from FIRST_IDX to LAST_IDX.
// For each index it emits the low-bank record and then the high-bank record on a valid/ready stream.
module reg_dump_scanner #(
    parameter int FIRST_IDX = 0,
    parameter int LAST_IDX  = 15,
    parameter int SETTLE    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [4:0]            which_reg,
    input  logic [31:0]           reg_content,
    input  logic [31:0]           high_reg_content,
    reg_dump_scanner_if.master    out_if,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    if (FIRST_IDX < 0 || FIRST_IDX > 15 || LAST_IDX < FIRST_IDX || LAST_IDX > 15 ||
        SETTLE < 0 || SETTLE > 15) begin : g_bad_cfg
        $error("reg_dump_scanner: illegal FIRST_IDX/LAST_IDX/SETTLE configuration");
    end

    localparam logic [3:0] FIRST_I  = 4'(FIRST_IDX);
    localparam logic [3:0] LAST_I   = 4'(LAST_IDX);
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_SEND_LO = 3'd2,
        S_SEND_HI = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  which_reg_q, which_reg_d;
    logic [31:0] lo_buf_q, lo_buf_d;
    logic [31:0] hi_buf_q, hi_buf_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_idx_q, out_idx_d;
    logic [31:0] out_data_q, out_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        handshake;

    assign handshake = out_valid_q && out_if.out_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        which_reg_d = which_reg_q;
        lo_buf_d    = lo_buf_q;
        hi_buf_d    = hi_buf_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    idx_d       = FIRST_I;
                    which_reg_d = {1'b0, FIRST_I};
                    cnt_d       = SETTLE_C;
                    state_d     = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    lo_buf_d = reg_content;
                    hi_buf_d = high_reg_content;
                    state_d  = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                if (handshake) state_d = S_SEND_HI;
            end
            S_SEND_HI: begin
                if (handshake) begin
                    if (idx_q == LAST_I) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d       = idx_q + 4'd1;
                        which_reg_d = {1'b0, 4'(idx_q + 4'd1)};
                        cnt_d       = SETTLE_C;
                        state_d     = S_SETTLE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over any handshake on the same edge; the record is simply dropped.
        if (abort && state_q != S_IDLE) state_d = S_IDLE;

        out_valid_d = (state_d == S_SEND_LO) || (state_d == S_SEND_HI);
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        if (state_d == S_SEND_LO) begin
            out_idx_d  = {1'b0, idx_d};
            out_data_d = lo_buf_d;
        end else if (state_d == S_SEND_HI) begin
            out_idx_d  = {1'b1, idx_d};
            out_data_d = hi_buf_d;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            cnt_q       <= 4'd0;
            which_reg_q <= 5'd0;
            lo_buf_q    <= 32'd0;
            hi_buf_q    <= 32'd0;
            out_valid_q <= 1'b0;
            out_idx_q   <= 5'd0;
            out_data_q  <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            which_reg_q <= which_reg_d;
            lo_buf_q    <= lo_buf_d;
            hi_buf_q    <= hi_buf_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign which_reg       = which_reg_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_idx   = out_idx_q;
    assign out_if.out_data  = out_data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Bench for reg_dump_scanner: default-configured instance plus a SETTLE=0 single-index instance,
// each driven against a register file model r[n] = 0x100 + n.
module tb_reg_dump_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, abort_a, start_b, abort_b;
    logic [4:0]  which_a, which_b;
    logic [31:0] lo_a, hi_a, lo_b, hi_b;
    logic        busy_a, done_a, busy_b, done_b;
    logic [2:0]  dbg_a, dbg_b;

    reg_dump_scanner_if ifa();
    reg_dump_scanner_if ifb();

    assign lo_a = 32'h100 + {27'd0, which_a};
    assign hi_a = 32'h110 + {27'd0, which_a};
    assign lo_b = 32'h100 + {27'd0, which_b};
    assign hi_b = 32'h110 + {27'd0, which_b};

    reg_dump_scanner dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .which_reg(which_a), .reg_content(lo_a), .high_reg_content(hi_a),
        .out_if(ifa), .busy(busy_a), .done(done_a), .dbg_state(dbg_a)
    );

    reg_dump_scanner #(.FIRST_IDX(5), .LAST_IDX(5), .SETTLE(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .which_reg(which_b), .reg_content(lo_b), .high_reg_content(hi_b),
        .out_if(ifb), .busy(busy_b), .done(done_b), .dbg_state(dbg_b)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [36:0] exp_q[$];
    logic [36:0] exp_b_q[$];
    int done_cnt_a = 0, done_cnt_b = 0, rec_cnt_a = 0;
    bit          stall_prev = 1'b0;
    logic [4:0]  st_idx;
    logic [31:0] st_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input int pct);
        ifa.out_ready = ($urandom_range(0, 99) < pct);
    endtask

    task automatic push_full_dump();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({5'(i), 32'(32'h100 + i)});
            exp_q.push_back({5'(i + 16), 32'(32'h110 + i)});
        end
    endtask

    // Monitor for instance A: scoreboard pop, stall stability, done pulse count.
    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && ifa.out_valid) begin
                chk("stall_idx_a", 64'(ifa.out_idx), 64'(st_idx));
                chk("stall_data_a", 64'(ifa.out_data), 64'(st_data));
            end
            if (ifa.out_valid && ifa.out_ready && !abort_a) begin
                rec_cnt_a++;
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL rec_a: got unexpected record idx %0d data 0x%0h, expected none",
                             ifa.out_idx, ifa.out_data);
                end else begin
                    chk("rec_a", 64'({ifa.out_idx, ifa.out_data}), 64'(exp_q.pop_front()));
                end
            end
            stall_prev = ifa.out_valid && !ifa.out_ready && !abort_a;
            st_idx     = ifa.out_idx;
            st_data    = ifa.out_data;
            if (done_a) done_cnt_a++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (ifb.out_valid && ifb.out_ready && !abort_b) begin
                if (exp_b_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL rec_b: got unexpected record idx %0d, expected none", ifb.out_idx);
                end else begin
                    chk("rec_b", 64'({ifb.out_idx, ifb.out_data}), 64'(exp_b_q.pop_front()));
                end
            end
            if (done_b) done_cnt_b++;
        end
    end

    task automatic run_dump_a(input int pct, input int exp_cycles, input int exp_recs);
        int cyc, first_v, d0, r0;
        d0 = done_cnt_a;
        r0 = rec_cnt_a;
        push_full_dump();
        start_a = 1'b1;
        set_ready(pct);
        tick();
        start_a = 1'b0;
        chk("busy_after_start", 64'(busy_a), 64'd1);
        cyc = 0;
        first_v = -1;
        while (!done_a && cyc < 5000) begin
            set_ready(pct);
            tick();
            cyc++;
            if (first_v < 0 && ifa.out_valid) first_v = cyc;
        end
        if (!done_a) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL dump_timeout: got no done after %0d cycles, expected done", cyc);
        end
        chk("first_valid_latency", 64'(first_v), 64'd2);
        if (exp_cycles >= 0) chk("dump_cycles", 64'(cyc), 64'(exp_cycles));
        chk("done_which_reg", 64'(which_a), 64'd15);
        ifa.out_ready = 1'b1;
        tick();
        chk("done_one_cycle", 64'(done_a), 64'd0);
        chk("idle_busy", 64'(busy_a), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("done_pulses", 64'(done_cnt_a - d0), 64'd1);
        chk("record_count", 64'(rec_cnt_a - r0), 64'(exp_recs));
    endtask

    typedef struct {
        int pct;         // out_ready probability in percent
        int exp_cycles;  // start edge to DONE, -1 when stalls make it variable
        int exp_recs;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int cyc, first_v, d0, r0;
        tbl[0] = '{100, 64, 32};
        tbl[1] = '{50, -1, 32};
        tbl[2] = '{20, -1, 32};
        tbl[3] = '{85, -1, 32};

        rst = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_which_reg", 64'(which_a), 64'd0);
        chk("rst_valid", 64'(ifa.out_valid), 64'd0);
        chk("rst_idx", 64'(ifa.out_idx), 64'd0);
        chk("rst_data", 64'(ifa.out_data), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_state", 64'(dbg_a), 64'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        tick();

        // Single-index, zero-settle instance: two records, done three cycles after start.
        exp_b_q.push_back({5'd5, 32'h105});
        exp_b_q.push_back({5'd21, 32'h115});
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 0;
        first_v = -1;
        while (!done_b && cyc < 100) begin
            tick();
            cyc++;
            if (first_v < 0 && ifb.out_valid) first_v = cyc;
        end
        chk("b_first_valid", 64'(first_v), 64'd1);
        chk("b_done_cycles", 64'(cyc), 64'd3);
        tick();
        chk("b_queue_drained", 64'(exp_b_q.size()), 64'd0);
        chk("b_done_pulses", 64'(done_cnt_b), 64'd1);
        chk("b_idle", 64'(busy_b), 64'd0);

        for (int v = 0; v < 4; v++) begin
            run_dump_a(tbl[v].pct, tbl[v].exp_cycles, tbl[v].exp_recs);
        end

        // abort in IDLE, alone and together with start, leaves the scanner idle
        start_a = 1'b1; abort_a = 1'b1;
        tick();
        chk("abort_start_idle_busy", 64'(busy_a), 64'd0);
        chk("abort_start_idle_state", 64'(dbg_a), 64'd0);
        start_a = 1'b0;
        tick();
        chk("abort_idle_busy", 64'(busy_a), 64'd0);
        abort_a = 1'b0;

        // abort while the high record of index 3 is offered with ready high
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({5'(i), 32'(32'h100 + i)});
            exp_q.push_back({5'(i + 16), 32'(32'h110 + i)});
        end
        exp_q.push_back({5'd3, 32'h103});
        d0 = done_cnt_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 0;
        while (!(ifa.out_valid && ifa.out_idx == 5'd19) && cyc < 500) begin
            tick();
            cyc++;
        end
        chk("abort_reached_rec19", 64'(ifa.out_idx), 64'd19);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abort_valid", 64'(ifa.out_valid), 64'd0);
        chk("abort_busy", 64'(busy_a), 64'd0);
        repeat (5) tick();
        chk("abort_no_done", 64'(done_cnt_a - d0), 64'd0);
        chk("abort_queue", 64'(exp_q.size()), 64'd0);
        chk("abort_stays_idle", 64'(ifa.out_valid), 64'd0);

        // reset asserted mid-SETTLE discards the dump; full dump afterwards
        push_full_dump();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 0;
        while (!(dbg_a == 3'd1 && which_a == 5'd2) && cyc < 500) begin
            tick();
            cyc++;
        end
        chk("reached_settle_idx2", 64'(which_a), 64'd2);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_state", 64'(dbg_a), 64'd0);
        chk("async_rst_which", 64'(which_a), 64'd0);
        chk("async_rst_busy", 64'(busy_a), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        tick();
        d0 = done_cnt_a;
        r0 = rec_cnt_a;
        repeat (5) tick();
        chk("post_rst_no_done", 64'(done_cnt_a - d0), 64'd0);
        chk("post_rst_no_rec", 64'(rec_cnt_a - r0), 64'd0);
        run_dump_a(100, 64, 32);

        // start pulses while busy are ignored
        push_full_dump();
        d0 = done_cnt_a;
        r0 = rec_cnt_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (10) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (7) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 0;
        while (!done_a && cyc < 500) begin
            tick();
            cyc++;
        end
        repeat (10) tick();
        chk("busy_start_done_pulses", 64'(done_cnt_a - d0), 64'd1);
        chk("busy_start_records", 64'(rec_cnt_a - r0), 64'd32);
        chk("busy_start_idle", 64'(busy_a), 64'd0);

        // start held high through DONE begins a second dump
        push_full_dump();
        push_full_dump();
        d0 = done_cnt_a;
        start_a = 1'b1;
        cyc = 0;
        tick();
        while (!done_a && cyc < 500) begin
            tick();
            cyc++;
        end
        tick();
        tick();
        start_a = 1'b0;
        chk("held_start_restarts", 64'(busy_a), 64'd1);
        cyc = 0;
        while (!done_a && cyc < 500) begin
            tick();
            cyc++;
        end
        tick();
        chk("held_start_done_pulses", 64'(done_cnt_a - d0), 64'd2);
        chk("held_start_queue", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
